logic_unit: RTL and testbench
=============================

# logic_unit

Parametrised, pipelined bitwise logic unit: the successor to the 8-bit combinational `not_func`. It applies one of eight bitwise operations to two `WIDTH`-bit operands. It carries the result through `STAGES` registered pipeline stages under a valid/ready handshake, and attaches zero and parity flags. It sits between an operand producer and a result consumer in the datapath, and keeps a saturating count of delivered results for status readback.

## Interface
- `WIDTH`, 8: operand/result width in bits, ≥1.
- `STAGES`, 2: pipeline register stages, 1..4.
- `CNT_W`, 16: width of the delivered-result counter.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat offered.
- `in_ready`  out  1  unit accepts a beat this cycle.
- `op`  in  3  operation select (see Operation).
- `in1`  in  WIDTH  operand A.
- `in2`  in  WIDTH  operand B; ignored by NOT/PASS.
- `out_valid`  out  1  result beat offered.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  WIDTH  result.
- `zero`  out  1  `out == 0`, qualified by `out_valid`.
- `parity`  out  1  XOR-reduction of `out`, qualified by `out_valid`.
- `cnt_clr`  in  1  synchronous clear of `done_cnt`.
- `done_cnt`  out  CNT_W  number of results delivered, saturating.

## Operation
- Op encoding:
  - 0 NOT(`in1`)
  - 1 AND
  - 2 OR
  - 3 XOR
  - 4 NAND
  - 5 NOR
  - 6 XNOR
  - 7 PASS(`in1`)
- The result is computed combinationally from `op`/`in1`/`in2` before stage 0. `zero` and `parity` are computed from that result and travel with it.
- Each stage k holds `v[k]`, `data[k]`, `zero[k]`, `parity[k]`.
- Stage k loads when `!v[k] || rdy[k+1]`:
  - `rdy[STAGES] = out_ready`.
  - `rdy[k] = !v[k] || rdy[k+1]`.
- Stage k loads `v[k-1]` and its payload. Stage 0 loads from the inputs, with `in_valid` as its valid.
- `in_ready = rdy[0]`.
- `out_valid`, `out`, `zero` and `parity` come from stage STAGES-1.
- Stalled stages hold their payload unchanged. No beat is dropped or duplicated.
- A beat is accepted on `in_valid && in_ready` and delivered on `out_valid && out_ready`.
- `done_cnt` increments on each delivery and saturates at all-ones.
- `cnt_clr` sets `done_cnt` to 0. Clear wins over a simultaneous delivery.
- While `out_valid=0`, `out` holds its last value. `zero` and `parity` are don't-care.

## Timing
- Reset (async assert, sync release): all `v[k]=0`, data 0, `zero=0`, `parity=0`, `done_cnt=0`.
- Outputs after reset: `out_valid=0`, `out=0`, `in_ready=1`.
- Latency: a beat accepted at edge N is visible at `out` after edge N+STAGES-1. It appears STAGES cycles after it is presented, with no stall.
- Throughput is one beat per cycle with `out_ready` held high.
- Back-pressure: `out_ready=0` while full:
  - `in_ready` drops combinationally in the same cycle.
  - The pipe holds at most STAGES beats.
  - Bubbles collapse: a stage with `v=0` always loads.
- Simultaneous accept and deliver on a full pipe is legal and shifts every stage.
- The `rdy` chain is combinational across all stages. This is acceptable for STAGES≤4.
- Reset mid-operation: all in-flight beats are discarded and `done_cnt` is cleared. No partial result is emitted.
- `op` values are all defined. No illegal-op state exists.

## Structure
- Package `logic_unit_pkg`:
  - `op_e` enum (`OP_NOT`..`OP_PASS`, 3 bits).
  - `LU_MAX_STAGES=4`.
  - Function `lu_eval(op, a, b)` returning the bitwise result.
- Sub-module `logic_unit_stage`: one valid/ready register slice for payload `{data, zero, parity}`. It is instantiated STAGES times in a generate loop.
- The top level holds the input-side evaluation, the generate chain, and the `done_cnt` counter.

## Test plan
All scenarios use WIDTH=8 and STAGES=2 unless noted.
- NOT sweep, `out_ready=1`: `op=0`, `in1`=00,FF,AA,55 on consecutive cycles → `out`=FF,00,55,AA, each 2 cycles after its input. Flags are `zero`=0,1,0,0 and `parity`=0,0,0,0.
- All ops: `in1`=0xC3, `in2`=0x0F, `op`=0..7 back-to-back → `out`=3C,03,CF,CC,FC,30,33,C3 in order. `done_cnt`=8.
- Back-pressure: stream 4 beats, `out_ready=0` from cycle 1 → `in_ready`=0 after 2 beats are held. Raise `out_ready` → all 4 beats arrive in order, none lost.
- Bubble collapse: a single beat, then idle, then `out_ready` toggling 1010 → the output order and values are preserved, and `out_valid` never asserts without a beat.
- Counter: CNT_W=2, deliver 5 beats → `done_cnt`=3 (saturated). Then `cnt_clr` in the same cycle as a delivery → `done_cnt`=0.
- Reset mid-stream: assert `rst` with 2 beats in flight → `out_valid`=0, `done_cnt`=0 and `in_ready`=1 immediately. No stale beat appears after release.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared operation encoding, limits and bitwise evaluation for logic_unit.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    localparam int unsigned LU_MAX_STAGES = 4;

    // Evaluated one bit at a time so it stays independent of the operand width.
    function automatic logic lu_eval(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// One pipeline register slice carrying {data, zero, parity} with its valid bit.
module logic_unit_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_zero,
    input  logic             in_parity,
    input  logic             load,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             zero_q;
    logic             parity_q;

    // Payload only moves with a real beat, so an emptied stage keeps its last data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else if (load) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q   <= in_data;
                zero_q   <= in_zero;
                parity_q <= in_parity;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_zero   = zero_q;
    assign out_parity = parity_q;

endmodule

// File: rtl/logic_unit.sv
// Pipelined bitwise logic unit with valid/ready handshake, result flags and a
// saturating delivered-result counter.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             parity,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] done_cnt
);

    // Out-of-range STAGES is clamped into the supported 1..LU_MAX_STAGES window.
    localparam int unsigned NStages = (STAGES == 0) ? 1 :
                                      ((STAGES > LU_MAX_STAGES) ? LU_MAX_STAGES : STAGES);

    logic [WIDTH-1:0] res;
    logic [NStages:0] v_vec;
    logic [NStages:0] z_vec;
    logic [NStages:0] p_vec;
    logic [NStages:0] rdy_vec;
    logic [WIDTH-1:0] d_arr [NStages+1];

    always_comb begin
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = lu_eval(op_e'(op), in1[i], in2[i]);
        end
    end

    assign v_vec[0] = in_valid;
    assign d_arr[0] = res;
    assign z_vec[0] = ~|res;
    assign p_vec[0] = ^res;

    // Ready chain unrolled from the stage valids so no signal feeds back on itself.
    always_comb begin
        logic r;
        r                = out_ready;
        rdy_vec          = '0;
        rdy_vec[NStages] = out_ready;
        for (int k = int'(NStages) - 1; k >= 0; k--) begin
            r          = !v_vec[k+1] || r;
            rdy_vec[k] = r;
        end
    end

    for (genvar k = 0; k < NStages; k++) begin : g_stage
        logic_unit_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v_vec[k]),
            .in_data   (d_arr[k]),
            .in_zero   (z_vec[k]),
            .in_parity (p_vec[k]),
            .load      (rdy_vec[k]),
            .out_valid (v_vec[k+1]),
            .out_data  (d_arr[k+1]),
            .out_zero  (z_vec[k+1]),
            .out_parity(p_vec[k+1])
        );
    end

    assign in_ready  = rdy_vec[0];
    assign out_valid = v_vec[NStages];
    assign out       = d_arr[NStages];
    assign zero      = z_vec[NStages];
    assign parity    = p_vec[NStages];

    logic [CNT_W-1:0] cnt_q;
    logic             deliver;

    assign deliver = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (deliver && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign done_cnt = cnt_q;

endmodule

// File: tb/tb_logic_unit.sv
// Directed self-checking bench for logic_unit: flags, all ops, back-pressure,
// bubble collapse, counter saturation/clear and mid-stream reset.
module tb_logic_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [7:0]  in1 = 8'h00;
    logic [7:0]  in2 = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  dout;
    logic        zero;
    logic        parity;
    logic        cnt_clr = 1'b0;
    logic [15:0] done_cnt;

    logic        c_in_valid = 1'b0;
    logic        c_in_ready;
    logic [2:0]  c_op = 3'd7;
    logic [7:0]  c_in1 = 8'h00;
    logic [7:0]  c_in2 = 8'h00;
    logic        c_out_valid;
    logic        c_out_ready = 1'b1;
    logic [7:0]  c_dout;
    logic        c_zero;
    logic        c_parity;
    logic        c_cnt_clr = 1'b0;
    logic [1:0]  c_done_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] got_q[$];

    logic [2:0] s_op  [8];
    logic [7:0] s_a   [8];
    logic [7:0] s_b   [8];
    logic [7:0] s_exp [8];
    logic       s_z   [8];
    logic       s_p   [8];

    always #5 clk = ~clk;

    logic_unit #(
        .WIDTH (8),
        .STAGES(2),
        .CNT_W (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .in1      (in1),
        .in2      (in2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (dout),
        .zero     (zero),
        .parity   (parity),
        .cnt_clr  (cnt_clr),
        .done_cnt (done_cnt)
    );

    logic_unit #(
        .WIDTH (8),
        .STAGES(3),
        .CNT_W (2)
    ) dut_cnt (
        .clk      (clk),
        .rst      (rst),
        .in_valid (c_in_valid),
        .in_ready (c_in_ready),
        .op       (c_op),
        .in1      (c_in1),
        .in2      (c_in2),
        .out_valid(c_out_valid),
        .out_ready(c_out_ready),
        .out      (c_dout),
        .zero     (c_zero),
        .parity   (c_parity),
        .cnt_clr  (c_cnt_clr),
        .done_cnt (c_done_cnt)
    );

    always @(posedge clk) begin
        if (out_valid && out_ready) got_q.push_back(dout);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [2:0] o, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] e, input logic z,
                           input logic p);
        s_op[i]  = o;
        s_a[i]   = a;
        s_b[i]   = b;
        s_exp[i] = e;
        s_z[i]   = z;
        s_p[i]   = p;
    endtask

    // Back-to-back beats on the STAGES=2 unit with out_ready high.
    task automatic run_stream(input int n, input string tag);
        for (int j = 0; j <= n; j++) begin
            if (j < n) begin
                in_valid = 1'b1;
                op       = s_op[j];
                in1      = s_a[j];
                in2      = s_b[j];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (j == 0) begin
                check({tag, "_latency_valid"}, out_valid, 0);
            end else begin
                check($sformatf("%s_valid%0d", tag, j - 1), out_valid, 1);
                check($sformatf("%s_out%0d", tag, j - 1), dout, s_exp[j-1]);
                check($sformatf("%s_zero%0d", tag, j - 1), zero, s_z[j-1]);
                check($sformatf("%s_parity%0d", tag, j - 1), parity, s_p[j-1]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", dout, 8'h00);
        check("rst_in_ready", in_ready, 1);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_zero", zero, 0);
        check("rst_parity", parity, 0);
        check("rst_c_in_ready", c_in_ready, 1);
        check("rst_c_done_cnt", c_done_cnt, 0);

        // NOT sweep with flags
        set_vec(0, 3'd0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
        set_vec(1, 3'd0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
        set_vec(2, 3'd0, 8'hAA, 8'h00, 8'h55, 1'b0, 1'b0);
        set_vec(3, 3'd0, 8'h55, 8'h00, 8'hAA, 1'b0, 1'b0);
        run_stream(4, "not");
        tick();
        check("not_drained_valid", out_valid, 0);
        check("not_out_holds", dout, 8'hAA);
        check("not_done_cnt", done_cnt, 4);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_done_cnt", done_cnt, 0);

        // All eight ops on C3 / 0F
        set_vec(0, 3'd0, 8'hC3, 8'h0F, 8'h3C, 1'b0, 1'b0);
        set_vec(1, 3'd1, 8'hC3, 8'h0F, 8'h03, 1'b0, 1'b0);
        set_vec(2, 3'd2, 8'hC3, 8'h0F, 8'hCF, 1'b0, 1'b0);
        set_vec(3, 3'd3, 8'hC3, 8'h0F, 8'hCC, 1'b0, 1'b0);
        set_vec(4, 3'd4, 8'hC3, 8'h0F, 8'hFC, 1'b0, 1'b0);
        set_vec(5, 3'd5, 8'hC3, 8'h0F, 8'h30, 1'b0, 1'b0);
        set_vec(6, 3'd6, 8'hC3, 8'h0F, 8'h33, 1'b0, 1'b0);
        set_vec(7, 3'd7, 8'hC3, 8'h0F, 8'hC3, 1'b0, 1'b0);
        run_stream(8, "ops");
        tick();
        check("ops_done_cnt", done_cnt, 8);
        check("ops_drained_valid", out_valid, 0);
        check("ops_out_holds", dout, 8'hC3);

        // Back-pressure: fill with out_ready low, then drain
        got_q.delete();
        op        = 3'd7;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in1       = 8'h11;
        tick();
        in1 = 8'h22;
        check("bp_ready_one_held", in_ready, 1);
        tick();
        in1 = 8'h33;
        check("bp_ready_full", in_ready, 0);
        check("bp_valid_full", out_valid, 1);
        check("bp_out_full", dout, 8'h11);
        tick();
        tick();
        check("bp_ready_still_full", in_ready, 0);
        check("bp_out_held", dout, 8'h11);
        check("bp_none_delivered", got_q.size(), 0);
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", in_ready, 1);
        tick();
        in1 = 8'h44;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("bp_drained_valid", out_valid, 0);
        check("bp_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("bp_order0", got_q[0], 8'h11);
            check("bp_order1", got_q[1], 8'h22);
            check("bp_order2", got_q[2], 8'h33);
            check("bp_order3", got_q[3], 8'h44);
        end

        // Bubble collapse with out_ready toggling 1010
        got_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in1       = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        check("bub_collapsed_valid", out_valid, 1);
        check("bub_collapsed_out", dout, 8'h5A);
        check("bub_ready_with_hole", in_ready, 1);
        in_valid = 1'b1;
        in1      = 8'h3C;
        tick();
        in_valid = 1'b0;
        check("bub_ready_full", in_ready, 0);
        for (int j = 0; j < 4; j++) begin
            out_ready = (j % 2 == 0);
            #1;
            check($sformatf("bub_valid%0d", j), out_valid, (j < 3) ? 1 : 0);
            tick();
        end
        out_ready = 1'b1;
        repeat (2) tick();
        check("bub_idle_valid", out_valid, 0);
        check("bub_out_holds", dout, 8'h3C);
        check("bub_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("bub_order0", got_q[0], 8'h5A);
            check("bub_order1", got_q[1], 8'h3C);
        end

        // Saturating counter on the CNT_W=2, STAGES=3 instance
        for (int j = 0; j < 5; j++) begin
            c_in_valid = 1'b1;
            c_in1      = 8'(j + 1);
            tick();
            if (j == 1) check("cnt_latency_valid", c_out_valid, 0);
            if (j == 2) begin
                check("cnt_first_valid", c_out_valid, 1);
                check("cnt_first_out", c_dout, 8'h01);
            end
            if (j == 4) check("cnt_mid_count", c_done_cnt, 2);
        end
        c_in_valid = 1'b0;
        repeat (4) tick();
        check("cnt_saturated", c_done_cnt, 3);
        check("cnt_drained_valid", c_out_valid, 0);
        c_in_valid = 1'b1;
        c_in1      = 8'h99;
        tick();
        c_in_valid = 1'b0;
        repeat (2) tick();
        check("cnt_clr_beat_valid", c_out_valid, 1);
        c_cnt_clr = 1'b1;
        tick();
        c_cnt_clr = 1'b0;
        check("cnt_clr_wins", c_done_cnt, 0);
        check("cnt_clr_delivered", c_out_valid, 0);

        // Reset with two beats in flight
        check("pre_rst_done_cnt", done_cnt, 14);
        got_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in1       = 8'h77;
        tick();
        in1 = 8'h88;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_done_cnt", done_cnt, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out", dout, 8'h00);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("post_rst_no_stale", got_q.size(), 0);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_done_cnt", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
